// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master (instruction fetch / data) to one-slave Wishbone B4
// classic arbiter. Round-robin between contending masters, grant held for the
// whole cyc window, bus mirrored combinationally from the granted master.
// Optional stall abort is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  input  logic [31:0] iwbs_addr_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2, ABORT = 2'd3} state_e;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   timeout;
  logic   granted;

  assign granted = (state_q == GNT_I) || (state_q == GNT_D);

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Abort fires in the stalled strobe cycle once the counter has hit the limit
  always_comb begin
    timeout = granted && wbm_stb_o && !wbm_ack_i && !wbm_err_i && (cnt_q >= TO_LIM);
  end

  // Count unterminated strobe cycles; any termination or state change restarts
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || wbm_ack_i || wbm_err_i) cnt_d = '0;
    else if (granted && wbm_stb_o)                      cnt_d = cnt_q + 16'd1;
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
  logic unused_timeout;
  assign unused_timeout = ^TO_LIM;
`endif

  // Arbitration: round-robin on contention, hold grant until owner drops cyc
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        if (dwbs_cyc_i && (!iwbs_cyc_i || !last_d_q)) begin
          state_d  = GNT_D;
          last_d_d = 1'b1;
        end else if (iwbs_cyc_i) begin
          state_d  = GNT_I;
          last_d_d = 1'b0;
        end
      end
      GNT_I: begin
        if (!iwbs_cyc_i)  state_d = IDLE;
        else if (timeout) state_d = ABORT;
      end
      GNT_D: begin
        if (!dwbs_cyc_i)  state_d = IDLE;
        else if (timeout) state_d = ABORT;
      end
      // last_d still names the aborted master; wait for it to give up the cycle
      ABORT: begin
        if (!(last_d_q ? dwbs_cyc_i : iwbs_cyc_i)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin history registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Bus mux: mirror the granted master, route terminations only to it
  always_comb begin
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = 4'h0;
    wbm_addr_o = 32'h0;
    wbm_dat_o  = 32'h0;
    iwbs_ack_o = 1'b0;
    iwbs_err_o = 1'b0;
    dwbs_ack_o = 1'b0;
    dwbs_err_o = 1'b0;
    iwbs_dat_o = wbm_dat_i;
    dwbs_dat_o = wbm_dat_i;
    case (state_q)
      GNT_I: begin
        wbm_cyc_o  = iwbs_cyc_i;
        wbm_stb_o  = iwbs_stb_i;
        wbm_sel_o  = 4'hF;
        wbm_addr_o = iwbs_addr_i;
        iwbs_ack_o = wbm_ack_i;
        iwbs_err_o = wbm_err_i | timeout;
      end
      GNT_D: begin
        wbm_cyc_o  = dwbs_cyc_i;
        wbm_stb_o  = dwbs_stb_i;
        wbm_we_o   = dwbs_we_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
        dwbs_ack_o = wbm_ack_i;
        dwbs_err_o = wbm_err_i | timeout;
      end
      default: ;
    endcase
  end

endmodule
